mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-outstanding memory port between an instruction-fetch
//   requester (i_*) and a data requester (d_*). Conflicts are resolved
//   round-robin on the last granted port. Only one memory transaction may be
//   in flight; the owner's response is forwarded combinationally.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   i_req_*               fetch request channel (valid/ready/addr), read only
//   i_resp_*              fetch response (valid/error/rdata)
//   d_req_*               data request channel (valid/ready/addr/wen/wdata)
//   d_resp_*              data response (valid/error/rdata)
//   mem_req_*             request to memory (valid/ready/addr/wen/wdata)
//   mem_resp_*            response from memory (valid/error/rdata)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    output logic                  i_req_ready,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_resp_valid,
    output logic                  i_resp_error,
    output logic [31:0]           i_resp_rdata,

    output logic                  d_req_ready,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_req_wen,
    input  logic [31:0]           d_req_wdata,
    output logic                  d_resp_valid,
    output logic                  d_resp_error,
    output logic [31:0]           d_resp_rdata,

    input  logic                  mem_req_ready,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [31:0]           mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic                  mem_resp_error,
    input  logic [31:0]           mem_resp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_I,
        S_WAIT_D
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   last_grant_next;
    logic   any_valid;
    logic   grant_d;

    // Arbitration decision. Data wins when it is the only requester, or when
    // both request and fetch was the port granted most recently.
    always_comb begin
        any_valid = i_req_valid | d_req_valid;
        grant_d   = d_req_valid & (~i_req_valid | (last_grant == GRANT_I));
    end

    // State and round-robin pointer. Reset points last_grant at data so the
    // first conflict after reset goes to fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= GRANT_D;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Next-state and output decode. While idle the request side is a pure
    // mux of the granted port; while waiting, requests are blocked and only
    // the owner sees the memory response strobe.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        mem_req_wen     = 1'b0;
        mem_req_wdata   = '0;
        i_req_ready     = 1'b0;
        d_req_ready     = 1'b0;
        i_resp_valid    = 1'b0;
        i_resp_error    = 1'b0;
        d_resp_valid    = 1'b0;
        d_resp_error    = 1'b0;
        i_resp_rdata    = mem_resp_rdata;
        d_resp_rdata    = mem_resp_rdata;

        unique case (state)
            S_IDLE: begin
                mem_req_valid = any_valid;
                mem_req_addr  = grant_d ? d_req_addr : i_req_addr;
                mem_req_wen   = grant_d & d_req_wen;
                mem_req_wdata = grant_d ? d_req_wdata : '0;
                i_req_ready   = ~grant_d & mem_req_ready;
                d_req_ready   = grant_d & mem_req_ready;
                if (any_valid && mem_req_ready) begin
                    state_next      = grant_d ? S_WAIT_D : S_WAIT_I;
                    last_grant_next = grant_d ? GRANT_D : GRANT_I;
                end
            end
            S_WAIT_I: begin
                i_resp_valid = mem_resp_valid;
                i_resp_error = mem_resp_error;
                if (mem_resp_valid) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT_D: begin
                d_resp_valid = mem_resp_valid;
                d_resp_error = mem_resp_error;
                if (mem_resp_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. Directed scenarios followed by a
//   randomized run, all compared against a transaction-level model that
//   tracks only "who owns the memory" and "who was granted last".
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req_ready, i_req_valid;
    logic [AW-1:0] i_req_addr;
    logic          i_resp_valid, i_resp_error;
    logic [31:0]   i_resp_rdata;
    logic          d_req_ready, d_req_valid;
    logic [AW-1:0] d_req_addr;
    logic          d_req_wen;
    logic [31:0]   d_req_wdata;
    logic          d_resp_valid, d_resp_error;
    logic [31:0]   d_resp_rdata;
    logic          mem_req_ready, mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [31:0]   mem_req_wdata;
    logic          mem_resp_valid, mem_resp_error;
    logic [31:0]   mem_resp_rdata;

    int total = 0;
    int bad   = 0;

    // Model: owner 0 = memory free, 1 = fetch outstanding, 2 = data outstanding.
    // last_port 1 = fetch granted last, 2 = data granted last.
    int owner;
    int last_port;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_ready    (i_req_ready),
        .i_req_valid    (i_req_valid),
        .i_req_addr     (i_req_addr),
        .i_resp_valid   (i_resp_valid),
        .i_resp_error   (i_resp_error),
        .i_resp_rdata   (i_resp_rdata),
        .d_req_ready    (d_req_ready),
        .d_req_valid    (d_req_valid),
        .d_req_addr     (d_req_addr),
        .d_req_wen      (d_req_wen),
        .d_req_wdata    (d_req_wdata),
        .d_resp_valid   (d_resp_valid),
        .d_resp_error   (d_resp_error),
        .d_resp_rdata   (d_resp_rdata),
        .mem_req_ready  (mem_req_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_error (mem_resp_error),
        .mem_resp_rdata (mem_resp_rdata)
    );

    // Drive every DUT input in one go.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                                 input logic dv, input logic [31:0] da,
                                 input logic dw, input logic [31:0] dd,
                                 input logic mrdy, input logic mrv,
                                 input logic mre, input logic [31:0] mrd);
        i_req_valid    = iv;
        i_req_addr     = ia;
        d_req_valid    = dv;
        d_req_addr     = da;
        d_req_wen      = dw;
        d_req_wdata    = dd;
        mem_req_ready  = mrdy;
        mem_resp_valid = mrv;
        mem_resp_error = mre;
        mem_resp_rdata = mrd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Which port the model would grant right now (0 = none).
    function automatic int modelGrant();
        if (owner != 0)                   return 0;
        if (i_req_valid && d_req_valid)   return (last_port == 1) ? 2 : 1;
        if (i_req_valid)                  return 1;
        if (d_req_valid)                  return 2;
        return 0;
    endfunction

    // Compare all DUT outputs with what the model predicts for the current inputs.
    task automatic checkAll(input string tag);
        int g;
        logic exp_mv, exp_ir, exp_dr, exp_iv, exp_ie, exp_dv, exp_de;
        g      = modelGrant();
        exp_mv = (owner == 0) && (i_req_valid || d_req_valid);
        exp_ir = (owner == 0) && (g != 2) && mem_req_ready;
        exp_dr = (owner == 0) && (g == 2) && mem_req_ready;
        exp_iv = (owner == 1) && mem_resp_valid;
        exp_ie = (owner == 1) && mem_resp_error;
        exp_dv = (owner == 2) && mem_resp_valid;
        exp_de = (owner == 2) && mem_resp_error;
        checkOutput({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'(exp_mv));
        checkOutput({tag, ".i_req_ready"},   32'(i_req_ready),   32'(exp_ir));
        checkOutput({tag, ".d_req_ready"},   32'(d_req_ready),   32'(exp_dr));
        checkOutput({tag, ".i_resp_valid"},  32'(i_resp_valid),  32'(exp_iv));
        checkOutput({tag, ".i_resp_error"},  32'(i_resp_error),  32'(exp_ie));
        checkOutput({tag, ".d_resp_valid"},  32'(d_resp_valid),  32'(exp_dv));
        checkOutput({tag, ".d_resp_error"},  32'(d_resp_error),  32'(exp_de));
        checkOutput({tag, ".i_resp_rdata"},  i_resp_rdata,       mem_resp_rdata);
        checkOutput({tag, ".d_resp_rdata"},  d_resp_rdata,       mem_resp_rdata);
        if (exp_mv) begin
            checkOutput({tag, ".mem_req_addr"},  mem_req_addr,
                        (g == 2) ? d_req_addr : i_req_addr);
            checkOutput({tag, ".mem_req_wen"},   32'(mem_req_wen),
                        (g == 2) ? 32'(d_req_wen) : 32'd0);
            checkOutput({tag, ".mem_req_wdata"}, mem_req_wdata,
                        (g == 2) ? d_req_wdata : 32'd0);
        end
    endtask

    task automatic modelReset();
        owner     = 0;
        last_port = 2;
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic modelUpdate();
        int g;
        if (!rst_n) begin
            modelReset();
        end else if (owner == 0) begin
            g = modelGrant();
            if (g != 0 && mem_req_ready) begin
                owner     = g;
                last_port = g;
            end
        end else if (mem_resp_valid) begin
            owner = 0;
        end
    endtask

    // One full cycle: drive at the falling edge, check, then take the rising edge.
    task automatic stepCycle(input string tag,
                             input logic iv, input logic [31:0] ia,
                             input logic dv, input logic [31:0] da,
                             input logic dw, input logic [31:0] dd,
                             input logic mrdy, input logic mrv,
                             input logic mre, input logic [31:0] mrd);
        @(negedge clk);
        applyStimulus(iv, ia, dv, da, dw, dd, mrdy, mrv, mre, mrd);
        #1;
        checkAll(tag);
        @(posedge clk);
        modelUpdate();
    endtask

    initial begin
        logic iv, dv, dw, mrdy, mrv, mre;
        logic [31:0] ia, da, dd, mrd;

        $display("[TB] start");
        rst_n = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkAll("reset_zero");
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checkAll("reset_ready");
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch then its response.
        stepCycle("fetch_req", 1, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0);
        stepCycle("fetch_rsp", 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hDEADBEEF);

        // Conflict: alternating grants with a zero-delay memory.
        for (int k = 0; k < 3; k++) begin
            stepCycle("conf_req", 1, 32'h200 + k, 1, 32'h300 + k, 0, 0, 1, 0, 0, 0);
            stepCycle("conf_rsp", 1, 32'h200 + k, 1, 32'h300 + k, 0, 0, 1, 1, 0, 32'h11 * k);
        end

        // Data write, response only on the data port.
        stepCycle("dwr_req", 0, 0, 1, 32'h40, 1, 32'h12345678, 1, 0, 0, 0);
        stepCycle("dwr_rsp", 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hCAFEF00D);

        // Error response completes the transaction normally.
        stepCycle("err_req", 1, 32'h0001_0000, 0, 0, 0, 0, 1, 0, 0, 0);
        stepCycle("err_rsp", 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0BADBAD0);
        stepCycle("err_idle", 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0);

        // Backpressure: request held for three cycles, then accepted.
        for (int k = 0; k < 3; k++)
            stepCycle("bp_hold", 1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("bp_go", 1, 32'h500, 0, 0, 0, 0, 1, 0, 0, 0);
        stepCycle("bp_rsp", 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h5);

        // Stray response while idle is ignored.
        stepCycle("stray_idle", 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h77);

        // Reset in the middle of a data transaction, then a late response.
        stepCycle("rst_dreq", 0, 0, 1, 32'h80, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle("rst_stray", 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h99);
        stepCycle("rst_after", 1, 32'h600, 0, 0, 0, 0, 1, 0, 0, 0);
        stepCycle("rst_after_rsp", 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h66);

        // Randomized traffic including dropped requests and stray responses.
        for (int n = 0; n < 300; n++) begin
            iv   = 1'($urandom_range(0, 1));
            dv   = 1'($urandom_range(0, 1));
            dw   = 1'($urandom_range(0, 1));
            mrdy = ($urandom_range(0, 9) < 7);
            mrv  = ($urandom_range(0, 9) < 5);
            mre  = mrv & ($urandom_range(0, 3) == 0);
            ia   = $urandom;
            da   = $urandom;
            dd   = $urandom;
            mrd  = $urandom;
            stepCycle("rand", iv, ia, dv, da, dw, dd, mrdy, mrv, mre, mrd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
